// File: rtl/cmac_rx_axis_pkt_chk.sv
// CMAC RX AXI-Stream packet checker: verifies the incrementing byte pattern, keep and length of
// each received packet and counts good/bad packets until PKT_NUM have been seen.
module cmac_rx_axis_pkt_chk #(
   parameter int unsigned PKT_NUM  = 1000,
   parameter int unsigned PKT_SIZE = 522
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stat_rx_aligned,
   input  logic         lbus_rx_restart_in,
   input  logic         rx_axis_tvalid,
   input  logic [511:0] rx_axis_tdata,
   input  logic [63:0]  rx_axis_tkeep,
   input  logic         rx_axis_tlast,
   input  logic         rx_axis_tuser,
   output logic         ctl_rx_enable,
   output logic         rx_gt_locked_led,
   output logic         rx_busy_led,
   output logic         rx_done_led,
   output logic [15:0]  rx_good_pkt_cnt,
   output logic [15:0]  rx_bad_pkt_cnt,
   output logic [3:0]   rx_err_flags
);

   typedef enum logic [2:0] {
      StIdle,
      StEnable,
      StWaitAlign,
      StReceive,
      StDone
   } state_e;

   localparam logic [15:0] PktSize = 16'(PKT_SIZE);
   localparam logic [16:0] PktNum  = 17'(PKT_NUM);

   state_e      state_q;
   logic [7:0]  beat_idx_q;
   logic [15:0] byte_cnt_q;
   logic [1:0]  pkt_err_q;  // {data, keep} seen on earlier beats of the current packet

   logic        beat_data_err;
   logic        beat_keep_err;
   logic [6:0]  keep_ones;
   logic [15:0] byte_cnt_d;
   logic [3:0]  pkt_flags;
   logic        pkt_bad;
   logic [15:0] good_d;
   logic [15:0] bad_d;
   logic [16:0] total_d;
   logic        beat_en;
   logic        pkt_end;

   // Expected byte i of beat k is (64*k + i) mod 256, so only beat_idx[1:0] matters.
   always_comb begin
      beat_data_err = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (rx_axis_tkeep[i] && (rx_axis_tdata[8*i +: 8] != {beat_idx_q[1:0], 6'(i)})) begin
            beat_data_err = 1'b1;
         end
      end
   end

   // A last beat must keep a non-empty run of bytes starting at byte 0.
   always_comb begin
      if (rx_axis_tlast) begin
         beat_keep_err = (rx_axis_tkeep == '0) ||
                         ((rx_axis_tkeep & (rx_axis_tkeep + 64'd1)) != '0);
      end else begin
         beat_keep_err = (rx_axis_tkeep != '1);
      end
   end

   always_comb begin
      keep_ones  = 7'($countones(rx_axis_tkeep));
      byte_cnt_d = byte_cnt_q + (rx_axis_tlast ? {9'd0, keep_ones} : 16'd64);
      pkt_flags  = {pkt_err_q[1] | beat_data_err,
                    pkt_err_q[0] | beat_keep_err,
                    rx_axis_tuser,
                    byte_cnt_d != PktSize};
      pkt_bad    = |pkt_flags;
      good_d     = rx_good_pkt_cnt;
      bad_d      = rx_bad_pkt_cnt;
      if (pkt_bad) begin
         if (rx_bad_pkt_cnt != 16'hFFFF) bad_d = rx_bad_pkt_cnt + 16'd1;
      end else begin
         if (rx_good_pkt_cnt != 16'hFFFF) good_d = rx_good_pkt_cnt + 16'd1;
      end
      total_d    = {1'b0, good_d} + {1'b0, bad_d};
      beat_en    = (state_q == StReceive) && rx_axis_tvalid;
      pkt_end    = beat_en && rx_axis_tlast;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= StIdle;
         ctl_rx_enable    <= 1'b0;
         rx_gt_locked_led <= 1'b0;
         rx_busy_led      <= 1'b0;
         rx_done_led      <= 1'b0;
         rx_good_pkt_cnt  <= '0;
         rx_bad_pkt_cnt   <= '0;
         rx_err_flags     <= '0;
         beat_idx_q       <= '0;
         byte_cnt_q       <= '0;
         pkt_err_q        <= '0;
      end else begin
         rx_gt_locked_led <= stat_rx_aligned;
         case (state_q)
            StIdle: begin
               state_q       <= StEnable;
               ctl_rx_enable <= 1'b1;
            end
            StEnable: begin
               state_q <= StWaitAlign;
            end
            StWaitAlign: begin
               beat_idx_q <= '0;
               byte_cnt_q <= '0;
               pkt_err_q  <= '0;
               if (rx_gt_locked_led) begin
                  state_q     <= StReceive;
                  rx_busy_led <= 1'b1;
               end
            end
            StReceive: begin
               if (pkt_end) begin
                  // A packet ending as alignment drops is still counted before leaving.
                  rx_good_pkt_cnt <= good_d;
                  rx_bad_pkt_cnt  <= bad_d;
                  rx_err_flags    <= rx_err_flags | pkt_flags;
                  beat_idx_q      <= '0;
                  byte_cnt_q      <= '0;
                  pkt_err_q       <= '0;
                  if (total_d == PktNum) begin
                     state_q     <= StDone;
                     rx_busy_led <= 1'b0;
                     rx_done_led <= 1'b1;
                  end else if (!rx_gt_locked_led) begin
                     state_q     <= StWaitAlign;
                     rx_busy_led <= 1'b0;
                  end
               end else if (!rx_gt_locked_led) begin
                  beat_idx_q  <= '0;
                  byte_cnt_q  <= '0;
                  pkt_err_q   <= '0;
                  state_q     <= StWaitAlign;
                  rx_busy_led <= 1'b0;
               end else if (beat_en) begin
                  if (beat_idx_q != 8'hFF) beat_idx_q <= beat_idx_q + 8'd1;
                  byte_cnt_q <= byte_cnt_d;
                  pkt_err_q  <= pkt_err_q | {beat_data_err, beat_keep_err};
               end
            end
            StDone: begin
               if (lbus_rx_restart_in) begin
                  rx_good_pkt_cnt <= '0;
                  rx_bad_pkt_cnt  <= '0;
                  rx_err_flags    <= '0;
                  state_q         <= StWaitAlign;
                  rx_done_led     <= 1'b0;
               end
            end
            default: begin
               state_q       <= StIdle;
               ctl_rx_enable <= 1'b0;
               rx_busy_led   <= 1'b0;
               rx_done_led   <= 1'b0;
            end
         endcase
      end
   end

endmodule
